// File: rtl/huff_bit_serializer.sv
// Huffman codeword parallel-to-serial stage: buffers {code,len} pairs in a small
// FIFO and shifts them out one bit per handshake, flagging first/last bits.
module huff_bit_serializer #(
  parameter int MAX_LEN    = 16,
  parameter int LEN_W      = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int MSB_FIRST  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MAX_LEN-1:0] in_code,
  input  logic [LEN_W-1:0]   in_len,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_bit,
  output logic               out_first,
  output logic               out_last,
  output logic               busy,
  output logic               err_len
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [MAX_LEN-1:0] r_mem_code [FIFO_DEPTH];
  logic [LEN_W-1:0]   r_mem_len  [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  state_t             r_state;
  state_t             w_state_nxt;
  logic [MAX_LEN-1:0] r_shift;
  logic [LEN_W-1:0]   r_cnt;
  logic               r_first;
  logic               r_err;

  logic               w_legal;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_out_xfer;
  logic               w_bit;
  logic [MAX_LEN-1:0] w_head_code;
  logic [LEN_W-1:0]   w_head_len;

  // Place the codeword so the bit to send next always sits at the output tap.
  function automatic logic [MAX_LEN-1:0] align_code(input logic [MAX_LEN-1:0] code,
                                                    input logic [LEN_W-1:0]   len);
    logic [LEN_W-1:0] lsh;
    lsh = LEN_W'(MAX_LEN) - len;
    if (MSB_FIRST != 0) align_code = code << lsh;
    else                align_code = code;
  endfunction

  function automatic logic [MAX_LEN-1:0] advance(input logic [MAX_LEN-1:0] sh);
    if (MSB_FIRST != 0) advance = sh << 1;
    else                advance = sh >> 1;
  endfunction

  assign w_legal      = (in_len != '0) && (in_len <= LEN_W'(MAX_LEN));
  assign w_fifo_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_fifo_empty = (r_count == '0);
  assign w_push       = in_valid && !w_fifo_full && w_legal;
  assign w_out_xfer   = (r_state == SHIFT) && out_ready;
  // Reload on the last bit's handshake keeps the stream gapless.
  assign w_pop        = !w_fifo_empty &&
                        ((r_state == IDLE) || (w_out_xfer && (r_cnt == '0)));
  assign w_head_code  = r_mem_code[r_rd_ptr];
  assign w_head_len   = r_mem_len[r_rd_ptr];
  assign w_bit        = (MSB_FIRST != 0) ? r_shift[MAX_LEN-1] : r_shift[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (!w_fifo_empty) w_state_nxt = SHIFT;
      SHIFT:   if (w_out_xfer && (r_cnt == '0) && w_fifo_empty) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_code[r_wr_ptr] <= in_code;
      r_mem_len[r_wr_ptr]  <= in_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_first  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_err <= in_valid && !w_fifo_full && !w_legal;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_pop) begin
        r_shift <= align_code(w_head_code, w_head_len);
        r_cnt   <= w_head_len - LEN_W'(1);
        r_first <= 1'b1;
      end else if (w_out_xfer && (r_cnt != '0)) begin
        r_shift <= advance(r_shift);
        r_cnt   <= r_cnt - LEN_W'(1);
        r_first <= 1'b0;
      end
    end
  end

  assign in_ready  = !w_fifo_full;
  assign out_valid = (r_state == SHIFT);
  assign out_bit   = out_valid && w_bit;
  assign out_first = out_valid && r_first;
  assign out_last  = out_valid && (r_cnt == '0);
  assign busy      = !w_fifo_empty || out_valid;
  assign err_len   = r_err;

endmodule

// File: tb/tb_huff_bit_serializer.sv
// Bench for huff_bit_serializer: table vectors, directed corner sequences and
// random traffic checked against a bit-queue reference model.
module tb_huff_bit_serializer;

  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;
  localparam int DEPTH   = 4;

  logic              clk;
  logic              rst_n;
  logic              in_valid, in_ready, out_valid, out_ready;
  logic [MAX_LEN-1:0] in_code;
  logic [LEN_W-1:0]   in_len;
  logic              out_bit, out_first, out_last, busy, err_len;

  logic              l_in_valid, l_in_ready, l_out_valid, l_out_ready;
  logic [MAX_LEN-1:0] l_in_code;
  logic [LEN_W-1:0]   l_in_len;
  logic              l_out_bit, l_out_first, l_out_last, l_busy, l_err_len;

  huff_bit_serializer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_len(in_len), .out_valid(out_valid), .out_ready(out_ready),
    .out_bit(out_bit), .out_first(out_first), .out_last(out_last), .busy(busy),
    .err_len(err_len));

  huff_bit_serializer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .in_code(l_in_code), .in_len(l_in_len), .out_valid(l_out_valid), .out_ready(l_out_ready),
    .out_bit(l_out_bit), .out_first(l_out_first), .out_last(l_out_last), .busy(l_busy),
    .err_len(l_err_len));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endfunction

  // Reference model: one entry per bit still to be emitted, tagged with the
  // edge on which its codeword was accepted.
  typedef struct {
    logic b;
    logic f;
    logic l;
    int   tag;
  } bit_t;

  bit_t q[$];
  int   cyc = 0;
  logic exp_err = 1'b0;
  int   err_seen = 0;
  int   xfer_seen = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      exp_err = 1'b0;
    end else begin
      logic ev;
      int   ncw;
      int   L;
      bit_t e;
      ev  = (q.size() != 0) && (q[0].tag + 1 < cyc);
      ncw = 0;
      foreach (q[i]) if (q[i].f) ncw++;
      if (q.size() != 0 && !q[0].f) ncw++;
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("busy", 32'(busy), 32'(q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'((ncw - (ev ? 1 : 0)) < DEPTH));
      chk("err_len", 32'(err_len), 32'(exp_err));
      if (ev) begin
        chk("out_bit", 32'(out_bit), 32'(q[0].b));
        chk("out_first", 32'(out_first), 32'(q[0].f));
        chk("out_last", 32'(out_last), 32'(q[0].l));
      end
      if (err_len) err_seen++;
      if (out_valid && out_ready) xfer_seen++;
      if (ev && out_ready) void'(q.pop_front());
      exp_err = 1'b0;
      if (in_valid && in_ready) begin
        L = int'(in_len);
        if (L >= 1 && L <= MAX_LEN) begin
          for (int k = 0; k < L; k++) begin
            e.b   = in_code[L-1-k];
            e.f   = (k == 0);
            e.l   = (k == L - 1);
            e.tag = cyc;
            q.push_back(e);
          end
        end else begin
          exp_err = 1'b1;
        end
      end
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push(input logic [15:0] c, input logic [4:0] l, input int tmax, output bit ok);
    in_valid = 1'b1;
    in_code  = c;
    in_len   = l;
    ok = 1'b0;
    for (int t = 0; t < tmax && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(output logic [15:0] bits, output int n);
    bits = '0;
    n = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        bits = {bits[14:0], out_bit};
        n++;
        if (out_last) break;
      end
    end
  endtask

  task automatic check_reset_vals(string nm);
    chk({nm, ".in_ready"}, 32'(in_ready), 32'd1);
    chk({nm, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({nm, ".out_bit"}, 32'(out_bit), 32'd0);
    chk({nm, ".out_first"}, 32'(out_first), 32'd0);
    chk({nm, ".out_last"}, 32'(out_last), 32'd0);
    chk({nm, ".busy"}, 32'(busy), 32'd0);
    chk({nm, ".err_len"}, 32'(err_len), 32'd0);
  endtask

  typedef struct {
    logic [15:0] code;
    logic [4:0]  len;
    logic [15:0] exp_bits;
  } vec_t;

  vec_t        tbl[5];
  logic [15:0] got;
  int          n, acc, e0, x0;
  bit          ok, okb;
  logic [7:0]  g_bits, g_first, g_last;
  logic        s_bit, s_first, s_last;

  initial begin
    tbl[0] = '{16'h01A5, 5'd9,  16'b1_1010_0101};
    tbl[1] = '{16'h0001, 5'd1,  16'b1};
    tbl[2] = '{16'hF0F3, 5'd4,  16'b0011};
    tbl[3] = '{16'h8001, 5'd16, 16'h8001};
    tbl[4] = '{16'hFFAC, 5'd6,  16'b10_1100};

    rst_n = 1'b0; in_valid = 1'b0; in_code = '0; in_len = '0; out_ready = 1'b1;
    l_in_valid = 1'b0; l_in_code = '0; l_in_len = '0; l_out_ready = 1'b1;
    #3;
    check_reset_vals("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("post_reset");

    // Single codewords, each into an idle block
    for (int i = 0; i < 5; i++) begin
      push(tbl[i].code, tbl[i].len, 4, ok);
      chk($sformatf("vec%0d.accept", i), 32'(ok), 32'd1);
      chk($sformatf("vec%0d.lat0", i), 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d.lat1", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d.first", i), 32'(out_first), 32'd1);
      collect(got, n);
      chk($sformatf("vec%0d.bits", i), 32'(got), 32'(tbl[i].exp_bits));
      chk($sformatf("vec%0d.nbits", i), 32'(n), 32'(tbl[i].len));
      @(posedge clk); #1;
    end
    chk("idle.out_valid", 32'(out_valid), 32'd0);
    chk("idle.busy", 32'(busy), 32'd0);

    // Back-to-back stream must come out gapless
    fork
      begin
        push(16'b101, 5'd3, 4, okb);
        push(16'b1, 5'd1, 4, okb);
        push(16'b0110, 5'd4, 4, okb);
      end
      begin
        n = 0;
        for (int t = 0; t < 20; t++) begin
          @(negedge clk);
          if (out_valid) break;
        end
        for (int i = 0; i < 8; i++) begin
          if (i > 0) @(negedge clk);
          if (out_valid) n++;
          g_bits[7-i]  = out_bit;
          g_first[7-i] = out_first;
          g_last[7-i]  = out_last;
        end
      end
    join
    chk("b2b.valid_run", 32'(n), 32'd8);
    chk("b2b.bits", 32'(g_bits), 32'b1011_0110);
    chk("b2b.first", 32'(g_first), 32'b1001_1000);
    chk("b2b.last", 32'(g_last), 32'b0011_0001);
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: shifter + FIFO absorb exactly DEPTH+1 codewords
    out_ready = 1'b0;
    acc = 0;
    push(16'b10, 5'd2, 3, ok); if (ok) acc++;
    push(16'b01, 5'd2, 3, ok); if (ok) acc++;
    push(16'b11, 5'd2, 3, ok); if (ok) acc++;
    push(16'b00, 5'd2, 3, ok); if (ok) acc++;
    push(16'b10, 5'd2, 3, ok); if (ok) acc++;
    push(16'b01, 5'd2, 3, ok); if (ok) acc++;
    chk("full.accepted", 32'(acc), 32'd5);
    chk("full.in_ready", 32'(in_ready), 32'd0);
    s_bit = out_bit; s_first = out_first; s_last = out_last;
    repeat (2) @(posedge clk);
    #1;
    chk("stall.bit", 32'(out_bit), 32'(s_bit));
    chk("stall.first", 32'(out_first), 32'(s_first));
    chk("stall.last", 32'(out_last), 32'(s_last));
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("drain.in_ready_a", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("drain.in_ready_b", 32'(in_ready), 32'd1);
    for (int t = 0; t < 30 && busy; t++) begin
      @(posedge clk); #1;
    end
    chk("drain.busy", 32'(busy), 32'd0);

    // Illegal lengths are dropped with an error pulse each
    e0 = err_seen; x0 = xfer_seen;
    push(16'h0000, 5'd0, 4, ok);
    push(16'h0005, 5'd17, 4, ok);
    push(16'b11, 5'd2, 4, ok);
    repeat (8) @(posedge clk);
    #1;
    chk("illegal.err_pulses", 32'(err_seen - e0), 32'd2);
    chk("illegal.bits_out", 32'(xfer_seen - x0), 32'd2);

    // LSB-first instance
    l_in_code = 16'b0011; l_in_len = 5'd4; l_in_valid = 1'b1;
    @(posedge clk); #1;
    l_in_valid = 1'b0;
    got = '0; n = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (l_out_valid) begin
        if (n == 0) chk("lsb.first", 32'(l_out_first), 32'd1);
        got = {got[14:0], l_out_bit};
        n++;
        if (l_out_last) break;
      end
    end
    chk("lsb.bits", 32'(got), 32'b1100);
    chk("lsb.nbits", 32'(n), 32'd4);
    @(posedge clk); #1;

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = $urandom_range(0, 1);
      in_code   = 16'($urandom);
      if ($urandom_range(0, 9) == 0)
        in_len = ($urandom_range(0, 1) != 0) ? 5'd0 : 5'($urandom_range(17, 31));
      else
        in_len = 5'($urandom_range(1, 16));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 200 && busy; t++) begin
      @(posedge clk); #1;
    end
    chk("rand.drained", 32'(busy), 32'd0);

    // Reset during bit 3 of a 9-bit codeword with two more queued
    push(16'h01A5, 5'd9, 4, ok);
    push(16'h0009, 5'd4, 4, ok);
    push(16'h0006, 5'd4, 4, ok);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #1;
      chk("after_reset.out_valid", 32'(out_valid), 32'd0);
    end
    chk("after_reset.busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
